// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM PHY command bus among the init, refresh,
// write and read engines. The bus belongs to the init engine until it
// reports done. After that a refresh interval timer runs, and one engine at a
// time gets a registered one-cycle grant pulse.
// Optional build macro: SDRAM_ARB_RR_EN. It adds write/read round-robin when
// both request together. Without it the priority is fixed: refresh > write > read.
//
// Handshake: i_wr_req / i_rd_req are levels held until granted and are only
// looked at while arbitrating. o_*_en is a one-cycle pulse in the first cycle
// of the granted state. The engine owns the bus until its i_*_end pulse, and
// an *_end pulse from an engine that does not own the bus is ignored.
module sdram_arbiter #(
  parameter int REF_PERIOD = 780,
  parameter int REF_CNT_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init_done,
  input  logic [3:0]  i_init_cmds,
  input  logic [10:0] i_init_addr,
  input  logic [1:0]  i_init_ba,
  output logic        o_ref_en,
  input  logic        i_ref_end,
  input  logic [3:0]  i_ref_cmds,
  input  logic [10:0] i_ref_addr,
  input  logic [1:0]  i_ref_ba,
  input  logic        i_wr_req,
  output logic        o_wr_en,
  input  logic        i_wr_end,
  input  logic [3:0]  i_wr_cmds,
  input  logic [10:0] i_wr_addr,
  input  logic [1:0]  i_wr_ba,
  input  logic        i_rd_req,
  output logic        o_rd_en,
  input  logic        i_rd_end,
  input  logic [3:0]  i_rd_cmds,
  input  logic [10:0] i_rd_addr,
  input  logic [1:0]  i_rd_ba,
  output logic [3:0]  sdr_cmds,
  output logic [10:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        o_ref_overrun,
  output logic [2:0]  o_dbg_state,
  output logic        o_dbg_ref_pending
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_ARB  = 3'd1,
    ST_REF  = 3'd2,
    ST_WR   = 3'd3,
    ST_RD   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 ref_en_q, ref_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [REF_CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic                 ref_pending_q, ref_pending_d;
  logic                 ref_overrun_q, ref_overrun_d;
  logic                 ref_clr;
  logic                 ref_wrap;
  logic                 cnt_run;
  logic                 wr_wins;

`ifdef SDRAM_ARB_RR_EN
  // last_grant: 0 = write was granted last, 1 = read was granted last
  logic                 last_grant_q, last_grant_d;

  // Write wins alone, or on a tie when the read engine had the previous grant
  always_comb begin
    wr_wins = i_wr_req && (!i_rd_req || last_grant_q);
  end
`else
  // Fixed priority: write always beats read
  always_comb begin
    wr_wins = i_wr_req;
  end
`endif

  // Next-state and grant decode; refresh is checked first in arbitration
  always_comb begin
    state_d  = state_q;
    ref_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    ref_clr  = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_INIT: if (i_init_done) state_d = ST_ARB;
      ST_ARB: begin
        if (ref_pending_q) begin
          state_d  = ST_REF;
          ref_en_d = 1'b1;
          ref_clr  = 1'b1;
        end else if (wr_wins) begin
          state_d = ST_WR;
          wr_en_d = 1'b1;
`ifdef SDRAM_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end else if (i_rd_req) begin
          state_d = ST_RD;
          rd_en_d = 1'b1;
`ifdef SDRAM_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end
      end
      ST_REF:  if (i_ref_end) state_d = ST_ARB;
      ST_WR:   if (i_wr_end)  state_d = ST_ARB;
      ST_RD:   if (i_rd_end)  state_d = ST_ARB;
      default: state_d = ST_INIT;
    endcase
  end

  // Refresh interval timer; a wrap beats a same-cycle clear of the pending flag
  always_comb begin
    cnt_run  = (state_q != ST_INIT);
    ref_wrap = cnt_run && (ref_cnt_q == REF_CNT_W'(REF_PERIOD - 1));
    if (!cnt_run)     ref_cnt_d = ref_cnt_q;
    else if (ref_wrap) ref_cnt_d = '0;
    else               ref_cnt_d = ref_cnt_q + REF_CNT_W'(1);
    if (ref_wrap)      ref_pending_d = 1'b1;
    else if (ref_clr)  ref_pending_d = 1'b0;
    else               ref_pending_d = ref_pending_q;
    ref_overrun_d = ref_overrun_q | (ref_wrap & ref_pending_q);
  end

  // State, grant, timer and sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      ref_en_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      ref_en_q      <= ref_en_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
`ifdef SDRAM_ARB_RR_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  // PHY mux driven from the registered state; NOP while arbitrating
  always_comb begin
    sdr_cmds = CMD_NOP;
    sdr_addr = '0;
    sdr_ba   = '0;
    case (state_q)
      ST_INIT: begin sdr_cmds = i_init_cmds; sdr_addr = i_init_addr; sdr_ba = i_init_ba; end
      ST_REF:  begin sdr_cmds = i_ref_cmds;  sdr_addr = i_ref_addr;  sdr_ba = i_ref_ba;  end
      ST_WR:   begin sdr_cmds = i_wr_cmds;   sdr_addr = i_wr_addr;   sdr_ba = i_wr_ba;   end
      ST_RD:   begin sdr_cmds = i_rd_cmds;   sdr_addr = i_rd_addr;   sdr_ba = i_rd_ba;   end
      default: begin sdr_cmds = CMD_NOP;     sdr_addr = '0;          sdr_ba = '0;        end
    endcase
  end

  assign o_ref_en          = ref_en_q;
  assign o_wr_en           = wr_en_q;
  assign o_rd_en           = rd_en_q;
  assign o_ref_overrun     = ref_overrun_q;
  assign o_dbg_state       = state_q;
  assign o_dbg_ref_pending = ref_pending_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter built with REF_PERIOD = 16.
// Cycle comments count edges from E0, the edge on which the arbiter leaves init.
module tb_sdram_arbiter;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_REF  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        i_init_done;
  logic [3:0]  i_init_cmds;
  logic [10:0] i_init_addr;
  logic [1:0]  i_init_ba;
  logic        o_ref_en, i_ref_end;
  logic [3:0]  i_ref_cmds;
  logic [10:0] i_ref_addr;
  logic [1:0]  i_ref_ba;
  logic        i_wr_req, o_wr_en, i_wr_end;
  logic [3:0]  i_wr_cmds;
  logic [10:0] i_wr_addr;
  logic [1:0]  i_wr_ba;
  logic        i_rd_req, o_rd_en, i_rd_end;
  logic [3:0]  i_rd_cmds;
  logic [10:0] i_rd_addr;
  logic [1:0]  i_rd_ba;
  logic [3:0]  sdr_cmds;
  logic [10:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        o_ref_overrun;
  logic [2:0]  o_dbg_state;
  logic        o_dbg_ref_pending;

  int n_vec  = 0;
  int n_fail = 0;

  sdram_arbiter #(.REF_PERIOD(16), .REF_CNT_W(5)) dut (
    .clk(clk), .rst(rst), .i_init_done(i_init_done),
    .i_init_cmds(i_init_cmds), .i_init_addr(i_init_addr), .i_init_ba(i_init_ba),
    .o_ref_en(o_ref_en), .i_ref_end(i_ref_end),
    .i_ref_cmds(i_ref_cmds), .i_ref_addr(i_ref_addr), .i_ref_ba(i_ref_ba),
    .i_wr_req(i_wr_req), .o_wr_en(o_wr_en), .i_wr_end(i_wr_end),
    .i_wr_cmds(i_wr_cmds), .i_wr_addr(i_wr_addr), .i_wr_ba(i_wr_ba),
    .i_rd_req(i_rd_req), .o_rd_en(o_rd_en), .i_rd_end(i_rd_end),
    .i_rd_cmds(i_rd_cmds), .i_rd_addr(i_rd_addr), .i_rd_ba(i_rd_ba),
    .sdr_cmds(sdr_cmds), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
    .o_ref_overrun(o_ref_overrun), .o_dbg_state(o_dbg_state),
    .o_dbg_ref_pending(o_dbg_ref_pending)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One edge, then state and all three grant pulses
  task automatic tick_chk(input string tag, input logic [2:0] st,
                          input logic ref_e, input logic wr_e, input logic rd_e);
    tick();
    chk({tag, ".state"},  16'(o_dbg_state), 16'(st));
    chk({tag, ".ref_en"}, 16'(o_ref_en),    16'(ref_e));
    chk({tag, ".wr_en"},  16'(o_wr_en),     16'(wr_e));
    chk({tag, ".rd_en"},  16'(o_rd_en),     16'(rd_e));
  endtask

  task automatic chk_phy(input string tag, input logic [3:0] c,
                         input logic [10:0] a, input logic [1:0] b);
    chk({tag, ".cmds"}, 16'(sdr_cmds), 16'(c));
    chk({tag, ".addr"}, 16'(sdr_addr), 16'(a));
    chk({tag, ".ba"},   16'(sdr_ba),   16'(b));
  endtask

  initial begin
    logic [2:0] g1;
    rst = 1'b1; i_init_done = 1'b0;
    i_init_cmds = 4'b0000; i_init_addr = 11'h123; i_init_ba = 2'd2;
    i_ref_end = 1'b0; i_ref_cmds = 4'b0001; i_ref_addr = 11'h400; i_ref_ba = 2'd3;
    i_wr_req = 1'b0; i_wr_end = 1'b0; i_wr_cmds = 4'b0100; i_wr_addr = 11'h055; i_wr_ba = 2'd1;
    i_rd_req = 1'b0; i_rd_end = 1'b0; i_rd_cmds = 4'b0101; i_rd_addr = 11'h2AA; i_rd_ba = 2'd2;

    // Reset for two cycles
    tick_chk("rst0", S_INIT, 0, 0, 0);
    tick_chk("rst1", S_INIT, 0, 0, 0);
    chk("rst.overrun", 16'(o_ref_overrun), 16'd0);
    chk("rst.pending", 16'(o_dbg_ref_pending), 16'd0);
    chk_phy("rst.phy", 4'b0000, 11'h123, 2'd2);
    rst = 1'b0;

    // Init hold: 50 cycles with init_done low
    for (int i = 0; i < 50; i++) begin
      tick_chk("init_hold", S_INIT, 0, 0, 0);
      chk("init_hold.cmds", 16'(sdr_cmds), 16'h0);
      chk("init_hold.pending", 16'(o_dbg_ref_pending), 16'd0);
    end
    i_init_done = 1'b1;
    tick_chk("e0_arb", S_ARB, 0, 0, 0);
    chk_phy("e0_nop", 4'b0111, 11'h0, 2'd0);

    // Write grant at E1, pulse only one cycle
    i_wr_req = 1'b1;
    tick_chk("e1_wr", S_WR, 0, 1, 0);
    chk_phy("e1_phy", 4'b0100, 11'h055, 2'd1);
    i_wr_req = 1'b0; i_wr_cmds = 4'b0110; i_rd_end = 1'b1;
    tick_chk("e2_wr_hold", S_WR, 0, 0, 0);
    chk("e2_follow", 16'(sdr_cmds), 16'(4'b0110));
    i_rd_end = 1'b0; i_wr_end = 1'b1;
    tick_chk("e3_arb", S_ARB, 0, 0, 0);
    chk_phy("e3_nop", 4'b0111, 11'h0, 2'd0);
    i_wr_end = 1'b0;

    // Idle until the first wrap at E16
    for (int i = 4; i <= 16; i++) begin
      tick_chk("idle", S_ARB, 0, 0, 0);
      chk("idle.pending", 16'(o_dbg_ref_pending), 16'(i == 16));
    end
    tick_chk("e17_ref", S_REF, 1, 0, 0);
    chk("e17_pending", 16'(o_dbg_ref_pending), 16'd0);
    chk_phy("e17_phy", 4'b0001, 11'h400, 2'd3);
    i_ref_end = 1'b1;
    tick_chk("e18_arb", S_ARB, 0, 0, 0);
    i_ref_end = 1'b0;

    // Both requests held; refresh must come before the next write grant
    i_wr_req = 1'b1; i_rd_req = 1'b1;
    g1 = RR ? S_RD : S_WR;
    tick_chk("e19_grant", g1, 0, !RR, RR);
    for (int i = 20; i <= 32; i++) begin
      tick_chk("busy1", g1, 0, 0, 0);
      chk("busy1.pending", 16'(o_dbg_ref_pending), 16'(i == 32));
    end
    i_wr_end = 1'b1; i_rd_end = 1'b1;
    tick_chk("e33_arb", S_ARB, 0, 0, 0);
    i_wr_end = 1'b0; i_rd_end = 1'b0;
    tick_chk("e34_ref_first", S_REF, 1, 0, 0);
    i_ref_end = 1'b1;
    tick_chk("e35_arb", S_ARB, 0, 0, 0);
    i_ref_end = 1'b0;
    tick_chk("e36_wr", S_WR, 0, 1, 0);

    // Overrun: hold the write past two wraps (E48 and E64)
    for (int i = 37; i <= 69; i++) begin
      tick_chk("long_wr", S_WR, 0, 0, 0);
      chk("long_wr.pending", 16'(o_dbg_ref_pending), 16'(i >= 48));
      chk("long_wr.overrun", 16'(o_ref_overrun), 16'(i >= 64));
    end
    i_wr_end = 1'b1;
    tick_chk("e70_arb", S_ARB, 0, 0, 0);
    i_wr_end = 1'b0;
    tick_chk("e71_ref", S_REF, 1, 0, 0);
    chk("e71_overrun_sticky", 16'(o_ref_overrun), 16'd1);
    i_ref_end = 1'b1;
    tick_chk("e72_arb", S_ARB, 0, 0, 0);
    i_ref_end = 1'b0;

    // Repeated contention: fixed priority keeps writing, round-robin alternates
    tick_chk("e73_grant", RR ? S_RD : S_WR, 0, !RR, RR);
    i_wr_end = 1'b1; i_rd_end = 1'b1;
    tick_chk("e74_arb", S_ARB, 0, 0, 0);
    i_wr_end = 1'b0; i_rd_end = 1'b0;
    tick_chk("e75_grant", S_WR, 0, 1, 0);
    i_wr_end = 1'b1; i_rd_end = 1'b1;
    tick_chk("e76_arb", S_ARB, 0, 0, 0);
    i_wr_end = 1'b0; i_rd_end = 1'b0;
    tick_chk("e77_grant", RR ? S_RD : S_WR, 0, !RR, RR);
    i_wr_end = 1'b1; i_rd_end = 1'b1;
    tick_chk("e78_arb", S_ARB, 0, 0, 0);
    i_wr_end = 1'b0; i_rd_end = 1'b0;

    // Read alone, then reset in the middle of the read
    i_wr_req = 1'b0;
    tick_chk("e79_rd", S_RD, 0, 0, 1);
    chk_phy("e79_phy", 4'b0101, 11'h2AA, 2'd2);
    i_rd_req = 1'b0; rst = 1'b1; i_init_cmds = 4'b0010;
    tick_chk("e80_rst", S_INIT, 0, 0, 0);
    chk("e80_overrun", 16'(o_ref_overrun), 16'd0);
    chk("e80_pending", 16'(o_dbg_ref_pending), 16'd0);
    chk_phy("e80_phy", 4'b0010, 11'h123, 2'd2);
    rst = 1'b0;
    tick_chk("e81_arb", S_ARB, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sequences and shares one SDRAM PHY command bus among four engines: init, auto-refresh, write (burst writer) and read.
- Holds the bus for the init engine until init completes.
- After init, runs a refresh interval timer and grants the bus to one engine at a time.
- Muxes the granted engine's cmd/addr/bank onto the PHY; the data path (DQ/DQM) is outside this block.

Parameters:
- REF_PERIOD, 780: cycles between refresh requests (7.8 us at 100 MHz).
- REF_CNT_W, 10: width of the refresh timer; must satisfy 2^REF_CNT_W > REF_PERIOD.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- i_init_done  in  1  init engine finished; level, stays high
- i_init_cmds / i_init_addr / i_init_ba  in  4/11/2  init engine command, address, bank
- o_ref_en  out  1  refresh grant, one-cycle pulse
- i_ref_end  in  1  refresh engine finished, one-cycle pulse
- i_ref_cmds / i_ref_addr / i_ref_ba  in  4/11/2  refresh engine command, address, bank
- i_wr_req  in  1  write request, level, held until granted
- o_wr_en  out  1  write grant, one-cycle pulse
- i_wr_end  in  1  write engine finished, pulse
- i_wr_cmds / i_wr_addr / i_wr_ba  in  4/11/2  write engine command, address, bank
- i_rd_req / o_rd_en / i_rd_end / i_rd_cmds / i_rd_addr / i_rd_ba  same widths and meaning as the write group, for the read engine
- sdr_cmds / sdr_addr / sdr_ba  out  4/11/2  PHY command, address, bank
- o_ref_overrun  out  1  sticky: a refresh interval expired while the previous refresh was still pending

Behaviour:
- States: ST_INIT, ST_ARB, ST_REF, ST_WR, ST_RD. Reset value ST_INIT.
- Reset values of outputs: all grants 0, o_ref_overrun 0. Also ref_pending 0, ref_cnt 0.
- Reset mid-operation: returns to ST_INIT on the next edge regardless of state; any granted engine is abandoned.
- Transitions:
  - ST_INIT -> ST_ARB when i_init_done = 1.
  - ST_ARB -> ST_REF if ref_pending.
  - ST_ARB -> ST_WR else if i_wr_req.
  - ST_ARB -> ST_RD else if i_rd_req.
  - ST_ARB stays otherwise.
  - ST_REF -> ST_ARB on i_ref_end; ST_WR -> ST_ARB on i_wr_end; ST_RD -> ST_ARB on i_rd_end.
  - An *_end pulse belonging to a non-current state is ignored.
- Arbitration latency: decision is made in ST_ARB cycle t. The grant pulse (o_ref_en/o_wr_en/o_rd_en) is registered and high only in cycle t+1, the first cycle of the new state. Minimum one ST_ARB cycle between consecutive grants.
- PHY mux: combinational on the registered state.
  - ST_INIT selects the init inputs.
  - ST_REF, ST_WR and ST_RD select the matching engine.
  - ST_ARB drives CMD_NOP (4'b0111), addr 0, ba 0.
- Refresh timer:
  - ref_cnt increments every cycle once i_init_done is high, i.e. in any state other than ST_INIT.
  - At ref_cnt == REF_PERIOD-1 it wraps to 0 and sets ref_pending.
  - ref_pending clears on the cycle the ST_ARB -> ST_REF transition is taken.
  - Simultaneous wrap and clear: set wins, so ref_pending stays 1.
  - Wrap while ref_pending is already 1: set o_ref_overrun, sticky until rst.
- Refresh priority: refresh preempts nothing in flight. A pending refresh waits for the current *_end and is then granted before any pending write/read.
- Requests are not latched: i_wr_req/i_rd_req are sampled only in ST_ARB.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Without the macro: fixed priority, refresh > write > read; a continuous write stream can starve reads.
- With the macro:
  - A last_grant register (0 = write, 1 = read, reset 1) is added.
  - When both i_wr_req and i_rd_req are high in ST_ARB with no refresh pending, the engine not last granted wins.
  - last_grant updates on each write/read grant.
  - Refresh remains highest priority.

Test Plan:
- Init hold: rst for 2 cycles, i_init_cmds = 4'b0000, i_init_done low for 50 cycles -> sdr_cmds = 4'b0000 throughout, no grants, ref_cnt stays 0; raise i_init_done -> ST_ARB next cycle, sdr_cmds = 4'b0111.
- Write grant: i_wr_req high in ST_ARB at cycle t -> o_wr_en high only at t+1, sdr_cmds follows i_wr_cmds until i_wr_end; NOP on the cycle after i_wr_end.
- Refresh priority (REF_PERIOD = 16): hold i_wr_req and i_rd_req high continuously -> every ref_pending causes an o_ref_en before the next o_wr_en. Without SDRAM_ARB_RR_EN, no o_rd_en ever.
- Overrun (REF_PERIOD = 16): grant a write, hold i_wr_end low for 40 cycles -> o_ref_overrun = 1 after the second wrap; after i_wr_end, o_ref_en is issued one ARB cycle later.
- Round-robin (SDRAM_ARB_RR_EN defined): both requests held, refresh idle -> grant order wr, rd, wr, rd starting with wr.
- Reset mid-burst: assert rst while in ST_RD -> next cycle state ST_INIT, all grants 0, o_ref_overrun 0, sdr_cmds = i_init_cmds.
